// File: rtl/gt_rx_align_pkg.sv
// Shared types and constants for the RX word aligner: FSM states, K28.5 comma, lane index.
package gt_rx_align_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } align_state_e;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/gt_rx_byte_rotator.sv
// Combinational 64->32 byte barrel shift (with matching 8->4 charisk shift) selecting
// the 4-byte window that starts at byte lane i_lane of {current, previous}.
module gt_rx_byte_rotator
  import gt_rx_align_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [7:0]  i_charisk,
  input  lane_t       i_lane,
  output logic [31:0] o_data,
  output logic [3:0]  o_charisk
);

  logic [63:0] data_sh;
  logic [7:0]  k_sh;

  always_comb begin
    data_sh   = i_data >> {i_lane, 3'b000};
    k_sh      = i_charisk >> i_lane;
    o_data    = data_sh[31:0];
    o_charisk = k_sh[3:0];
  end

endmodule

// File: rtl/gt_rx_word_align.sv
// K28.5 word aligner: hunts, qualifies and locks the comma lane, rotates it to byte 0.
// Optional lock-loss statistics counter enabled by defining GT_RX_ALIGN_STAT_EN.
module gt_rx_word_align
  import gt_rx_align_pkg::*;
#(
  parameter logic [7:0]  COMMA    = K28_5,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_gt_aligned,
  input  logic [31:0] i_rxdata,
  input  logic [3:0]  i_rxcharisk,
  output logic [31:0] o_rxdata,
  output logic [3:0]  o_rxcharisk,
  output logic        o_aligned,
  output logic [1:0]  o_lane,
  output logic [15:0] o_realign_cnt
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  align_state_e state_q, state_d;
  lane_t        lane_q, lane_d, lane_det;
  logic [3:0]   cnt_q, cnt_d, err_q, err_d, cnt_inc, err_inc;
  logic [2:0]   n_hits;
  logic         comma_one, comma_multi;

  logic [31:0]  cur_q, cur_d, prev_q, prev_d, rxdata_q, rxdata_d, rot_data;
  logic [3:0]   curk_q, curk_d, prevk_q, prevk_d, rxk_q, rxk_d, rot_k;
  logic         aligned_q, aligned_d;

  always_comb begin
    n_hits   = '0;
    lane_det = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_rxcharisk[i] && (i_rxdata[8*i +: 8] == COMMA)) begin
        n_hits   = n_hits + 3'd1;
        lane_det = lane_t'(i);
      end
    end
    comma_one   = (n_hits == 3'd1);
    comma_multi = (n_hits > 3'd1);
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cnt_inc = cnt_q + 4'd1;
    err_inc = err_q + 4'd1;
    if (!i_gt_aligned) begin
      state_d = HUNT;
      cnt_d   = '0;
      err_d   = '0;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (comma_one) begin
            lane_d = lane_det;
            err_d  = '0;
            if (LOCK_C == 4'd1) begin
              state_d = LOCKED;
              cnt_d   = '0;
            end else begin
              state_d = VERIFY;
              cnt_d   = 4'd1;
            end
          end
        end
        VERIFY: begin
          if (comma_multi) begin
            state_d = HUNT;
            cnt_d   = '0;
          end else if (comma_one) begin
            if (lane_det == lane_q) begin
              if (cnt_inc == LOCK_C) begin
                state_d = LOCKED;
                cnt_d   = '0;
                err_d   = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              lane_d = lane_det;
              cnt_d  = 4'd1;
            end
          end
        end
        LOCKED: begin
          if (comma_one && (lane_det == lane_q)) begin
            err_d = '0;
          end else if (comma_one || comma_multi) begin
            if (err_inc == LOSS_C) begin
              state_d = HUNT;
              err_d   = '0;
            end else begin
              err_d = err_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    aligned_d = (state_d == LOCKED);
  end

  // Two-word history: the comma word sits in prev when lane_q (updated on its own edge) selects it.
  always_comb begin
    cur_d    = i_rxdata;
    curk_d   = i_rxcharisk;
    prev_d   = cur_q;
    prevk_d  = curk_q;
    rxdata_d = rot_data;
    rxk_d    = rot_k;
  end

  gt_rx_byte_rotator u_rot (
    .i_data    ({cur_q, prev_q}),
    .i_charisk ({curk_q, prevk_q}),
    .i_lane    (lane_q),
    .o_data    (rot_data),
    .o_charisk (rot_k)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= HUNT;
      lane_q    <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      aligned_q <= 1'b0;
      cur_q     <= '0;
      curk_q    <= '0;
      prev_q    <= '0;
      prevk_q   <= '0;
      rxdata_q  <= '0;
      rxk_q     <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      aligned_q <= aligned_d;
      cur_q     <= cur_d;
      curk_q    <= curk_d;
      prev_q    <= prev_d;
      prevk_q   <= prevk_d;
      rxdata_q  <= rxdata_d;
      rxk_q     <= rxk_d;
    end
  end

  assign o_rxdata    = rxdata_q;
  assign o_rxcharisk = rxk_q;
  assign o_aligned   = aligned_q;
  assign o_lane      = lane_q;

`ifdef GT_RX_ALIGN_STAT_EN
  logic [15:0] realign_q, realign_d;
  logic        lock_lost;

  always_comb begin
    lock_lost = (state_q == LOCKED) && (state_d == HUNT);
    realign_d = realign_q;
    if (lock_lost && (realign_q != '1)) realign_d = realign_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) realign_q <= '0;
    else          realign_q <= realign_d;
  end

  assign o_realign_cnt = realign_q;
`else
  assign o_realign_cnt = '0;
`endif

endmodule

// File: doc/gt_rx_word_align.md
# gt_rx_word_align

Receive-side word aligner sitting directly downstream of one transceiver channel's 32-bit RX data/charisk outputs, in that channel's recovered RX clock domain. Searches for the K28.5 comma in any of the four byte lanes, qualifies its lane position over several occurrences, then rotates the byte stream so the comma always lands in byte 0. Exports a lock flag and the detected lane for the framing logic that follows.

## Interface
- COMMA, 8'hBC, comma byte value (valid only with its charisk bit set)
- LOCK_CNT, 4, consecutive same-lane commas required to declare lock (1..15)
- LOSS_CNT, 4, consecutive wrong-lane/invalid comma words that drop lock (1..15)
- i_clk  in  1  RX user clock of the channel
- i_rst_n  in  1  asynchronous active-low reset
- i_gt_aligned  in  1  channel comma-aligned / rx-done qualifier; low forces HUNT
- i_rxdata  in  32  raw RX word, byte 0 = bits 7:0
- i_rxcharisk  in  4  K flag per byte lane
- o_rxdata  out  32  lane-rotated RX word
- o_rxcharisk  out  4  lane-rotated K flags
- o_aligned  out  1  high in LOCKED
- o_lane  out  2  current comma lane in use for rotation
- o_realign_cnt  out  16  lock-loss counter (see Configuration)

## Operation
- Comma word: exactly one lane L with i_rxcharisk[L]=1 and byte L == COMMA. Multi-comma word: more than one such lane. Plain word: none.
- States HUNT, VERIFY, LOCKED; reset state HUNT, lane_reg=0, counters 0.
- HUNT: comma word -> lane_reg<=L, cnt<=1, VERIFY (if LOCK_CNT==1, straight to LOCKED). Other words: stay.
- VERIFY: comma word same lane -> cnt+1; on reaching LOCK_CNT -> LOCKED. Comma word different lane -> lane_reg<=new L, cnt<=1, stay VERIFY. Multi-comma -> HUNT. Plain -> no change.
- LOCKED: comma word same lane -> err<=0. Comma word different lane or multi-comma -> err+1; on reaching LOSS_CNT -> HUNT, err<=0, lane_reg unchanged. Plain -> no change.
- i_gt_aligned=0 in any state: next state HUNT, cnt/err cleared; overrides all other transitions that cycle.
- Rotation: prev_reg holds previous input word; output = bytes L..3 of prev followed by bytes 0..L-1 of current, i.e. ({cur,prev} >> 8*lane_reg)[31:0]; charisk rotated identically with 1-bit granularity per lane. lane 0 = pass-through.
- Data path runs in every state; consumers qualify with o_aligned.

## Timing
- All outputs registered; reset values: o_rxdata 0, o_rxcharisk 0, o_aligned 0, o_lane 0, o_realign_cnt 0.
- Latency: input word N appears (rotated) on o_rxdata 2 cycles after it is sampled; the word carrying the comma in lane L emerges with the comma in byte 0.
- lane_reg update at the edge sampling the comma word takes effect for that same word's output (one edge later).
- o_aligned rises at the edge sampling the LOCK_CNT-th qualifying comma word; falls at the edge sampling the LOSS_CNT-th bad word or first cycle with i_gt_aligned low.
- Counters saturate-free by construction (bounded by LOCK_CNT/LOSS_CNT), width 4.
- Async reset mid-stream: all state and data registers clear immediately; HUNT on release.

## Configuration
- GT_RX_ALIGN_STAT_EN defined: o_realign_cnt increments on each LOCKED->HUNT transition (either cause), saturating at 16'hFFFF.
- Not defined: counter logic absent, o_realign_cnt tied to 0.

## Structure
- Package gt_rx_align_pkg: state enum (HUNT, VERIFY, LOCKED), K28_5 constant 8'hBC, lane index type.
- Sub-module gt_rx_byte_rotator: combinational 64->32 byte barrel shift plus matching 8->4 charisk shift, selected by 2-bit lane.

## Test plan
- Reset, i_gt_aligned=1, comma 8'hBC/K in lane 2 every 4th word, filler data -> o_aligned high at 4th comma word; o_lane=2; every comma emerges as o_rxdata[7:0]=8'hBC, o_rxcharisk[0]=1, 2 cycles after input.
- Locked on lane 2, inject 3 commas in lane 1 then one in lane 2 -> stays locked, err cleared; then 4 in lane 1 -> o_aligned low, HUNT, o_realign_cnt=1 with macro, 0 without.
- VERIFY on lane 0 after 2 commas, comma appears in lane 3 -> o_lane=3, lock needs 4 fresh lane-3 commas.
- Byte 8'hBC with charisk=0 in any lane -> ignored, no state change; word with commas in lanes 0 and 2 during VERIFY -> HUNT.
- Locked, drop i_gt_aligned one cycle -> o_aligned low next edge, full relock required.
- Assert i_rst_n low mid-stream while locked -> all outputs 0 immediately; after release, 4 commas relock.
